// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage state encoding, instruction constants and default widths
package mips_pkg;
  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFC000000;
  localparam logic [31:0] NOP_WORD = 32'h0;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: instruction store with one synchronous write port and one asynchronous read port
module imem_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // program words land here only while loading; contents survive reset
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program loader, combinational instruction fetch and halt control for the PC
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(DEF_HALT_WORD)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic [31:0]           pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  halt,
  output logic                  out_of_range,
  output logic [ADDR_WIDTH:0]   loaded_count,
  output logic [1:0]            state_dbg
);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);
  fetch_state_t            state_q, state_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    in_load, fire, in_range;
  assign in_load  = state_q == S_LOAD;
  assign fire     = in_load && load_valid;
  assign in_range = pc < 32'(count_q);
  imem_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clock(clock),
    .we   (fire),
    .waddr(count_q[ADDR_WIDTH-1:0]),
    .wdata(load_data),
    .raddr(pc[ADDR_WIDTH-1:0]),
    .rdata(rd_data)
  );
  // state and load counter registers; reset makes all loaded words unreachable
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= S_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  // next state plus fetch outputs; halt is combinational so the PC freezes on the offending address
  always_comb begin
    load_ready   = in_load;
    out_of_range = !in_load && !in_range;
    instr        = (!in_load && in_range) ? rd_data : DATA_WIDTH'(NOP_WORD);
    halt         = state_q != S_RUN || out_of_range || instr == HALT_WORD;
    count_d      = fire ? count_q + 1'b1 : count_q;
    state_d      = state_q;
    if (fire && (load_last || count_q == LAST_IDX)) state_d = S_RUN;
    if (state_q == S_RUN && halt) state_d = S_HALTED;
  end
  assign loaded_count = count_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed load/fetch scenarios checked through an expectation scoreboard
module tb_instruction_fetch_unit;
  localparam logic [1:0] LD = 2'd0, RN = 2'd1, HT = 2'd2;
  localparam logic [31:0] HW = 32'hFC000000, JUNK = 32'hDEADBEEF;
  logic clock = 1'b0, reset = 1'b1, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0, pc = '0;
  logic        load_ready, halt, out_of_range;
  logic [31:0] instr;
  logic [8:0]  loaded_count;
  logic [1:0]  state_dbg;
  int tests = 0, fails = 0;
  typedef struct {
    string       name;
    logic [45:0] v;
  } exp_t;
  exp_t sb[$];
  always #5 clock = ~clock;
  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .pc(pc), .instr(instr), .halt(halt),
    .out_of_range(out_of_range), .loaded_count(loaded_count), .state_dbg(state_dbg)
  );
  // monitor: one expectation per cycle, compared mid-cycle against the live outputs
  always @(negedge clock) begin
    logic [45:0] act;
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {load_ready, halt, out_of_range, state_dbg, loaded_count, instr};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got rdy=%b halt=%b oor=%b st=%0d cnt=%0d instr=%h, want rdy=%b halt=%b oor=%b st=%0d cnt=%0d instr=%h",
                 e.name, act[45], act[44], act[43], act[42:41], act[40:32], act[31:0],
                 e.v[45], e.v[44], e.v[43], e.v[42:41], e.v[40:32], e.v[31:0]);
      end
    end
  end
  task automatic cyc(input string n, input logic v, input logic [31:0] d, input logic l,
                     input logic [31:0] p, input logic r, input logic h, input logic o,
                     input logic [1:0] s, input logic [8:0] c, input logic [31:0] i);
    load_valid = v; load_data = d; load_last = l; pc = p;
    sb.push_back('{n, {r, h, o, s, c, i}});
    @(posedge clock); #1;
  endtask
  task automatic ld(input string n, input logic [31:0] d, input logic l, input logic [8:0] c);
    cyc(n, 1'b1, d, l, 32'd0, 1'b1, 1'b1, 1'b0, LD, c, 32'd0);
  endtask
  task automatic gap(input string n, input logic [8:0] c);
    cyc(n, 1'b0, JUNK, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, LD, c, 32'd0);
  endtask
  task automatic run(input string n, input logic [31:0] p, input logic [31:0] i, input logic h,
                     input logic o, input logic [1:0] s, input logic [8:0] c);
    cyc(n, 1'b1, JUNK, 1'b1, p, 1'b0, h, o, s, c, i);
  endtask
  task automatic rst();
    reset = 1'b1; load_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask
  initial begin
    @(posedge clock); #1;
    rst();
    gap("reset_state", 9'd0);
    gap("empty_stays_load", 9'd0);
    ld("a_w0", 32'h20080005, 1'b0, 9'd0);
    ld("a_w1", 32'h21080001, 1'b0, 9'd1);
    ld("a_w2", HW, 1'b1, 9'd2);
    run("a_pc0", 32'd0, 32'h20080005, 1'b0, 1'b0, RN, 9'd3);
    run("a_pc1", 32'd1, 32'h21080001, 1'b0, 1'b0, RN, 9'd3);
    run("a_pc2_haltword", 32'd2, HW, 1'b1, 1'b0, RN, 9'd3);
    run("a_halted", 32'd2, HW, 1'b1, 1'b0, HT, 9'd3);
    run("a_halted_pc0", 32'd0, 32'h20080005, 1'b1, 1'b0, HT, 9'd3);
    rst();
    gap("reset_after_halt", 9'd0);
    ld("b_w0", 32'h11111111, 1'b0, 9'd0);
    ld("b_w1", 32'h22222222, 1'b1, 9'd1);
    run("b_pc1", 32'd1, 32'h22222222, 1'b0, 1'b0, RN, 9'd2);
    run("b_alias_101", 32'h101, 32'd0, 1'b1, 1'b1, RN, 9'd2);
    run("b_halt_102", 32'h102, 32'd0, 1'b1, 1'b1, HT, 9'd2);
    run("b_halt_pc2", 32'd2, 32'd0, 1'b1, 1'b1, HT, 9'd2);
    run("b_halt_pc0", 32'd0, 32'h11111111, 1'b1, 1'b0, HT, 9'd2);
    rst();
    ld("c_w0", 32'hAAAA0001, 1'b0, 9'd0);
    cyc("c_gap", 1'b0, 32'hBBBB0002, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, LD, 9'd1, 32'd0);
    ld("c_w1", 32'hCCCC0003, 1'b0, 9'd1);
    ld("c_w2", 32'hDDDD0004, 1'b1, 9'd2);
    run("c_pc0", 32'd0, 32'hAAAA0001, 1'b0, 1'b0, RN, 9'd3);
    run("c_pc1", 32'd1, 32'hCCCC0003, 1'b0, 1'b0, RN, 9'd3);
    run("c_pc2", 32'd2, 32'hDDDD0004, 1'b0, 1'b0, RN, 9'd3);
    run("c_pc3_oor", 32'd3, 32'd0, 1'b1, 1'b1, RN, 9'd3);
    rst();
    for (int k = 0; k < 4; k++) ld("d_load", 32'h30000000 + k, k == 3, 9'(k));
    run("d_pc3", 32'd3, 32'h30000003, 1'b0, 1'b0, RN, 9'd4);
    rst();
    gap("reset_during_run", 9'd0);
    ld("d_single", 32'h40000000, 1'b1, 9'd0);
    run("d_single_pc0", 32'd0, 32'h40000000, 1'b0, 1'b0, RN, 9'd1);
    run("d_single_pc1", 32'd1, 32'd0, 1'b1, 1'b1, RN, 9'd1);
    rst();
    for (int k = 0; k < 256; k++) ld("e_fill", 32'h10000000 + k, 1'b0, 9'(k));
    run("e_full_pc255", 32'd255, 32'h100000FF, 1'b0, 1'b0, RN, 9'd256);
    run("e_full_pc0", 32'd0, 32'h10000000, 1'b0, 1'b0, RN, 9'd256);
    run("e_full_pc256", 32'd256, 32'd0, 1'b1, 1'b1, RN, 9'd256);
    run("e_full_halted", 32'd128, 32'h10000080, 1'b1, 1'b0, HT, 9'd256);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clock);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
